// File: rtl/pipe_scheduler.sv
// pipe_scheduler
//   Game-side controller for the VGA pipe layer. Keeps NUM_PIPES scrolling
//   pipes; on every accepted frame_tick it sweeps the pipes one per cycle,
//   moving each left by SPEED, respawning any pipe that leaves the screen with
//   a pseudo-random gap height, and scoring pipes that slide past the bird.
//
// Ports
//   board_clk    in   system clock
//   reset        in   asynchronous, active-high
//   frame_tick   in   1-cycle pulse per frame (vsync start)
//   start        in   start / restart game (level, sampled each cycle)
//   halt         in   collision or stop request
//   pipe_x       out  {x3,x2,x1,x0}, 11-bit left edges; x >= SCREEN_W is off-screen
//   gap_top      out  {g3,g2,g1,g0}, 9-bit gap top rows
//   running      out  high in RUN and UPDATE
//   busy         out  high while a sweep is in progress (geometry unstable)
//   score        out  pipes passed, saturating at 255
//   score_pulse  out  1-cycle pulse per passed pipe
//   tick_overrun out  1-cycle pulse, one cycle after a frame_tick dropped mid-sweep
//
// Frame handshake: frame_tick is accepted only in RUN (and only if halt is low
// in that same cycle). Once accepted, busy is high for exactly NUM_PIPES
// cycles starting the next cycle; a frame_tick that arrives while busy is
// dropped and reported on tick_overrun. When busy falls, all geometry is final.
module pipe_scheduler #(
  parameter int          NUM_PIPES    = 4,
  parameter int          SCREEN_W     = 640,
  parameter int          PIPE_W       = 40,
  parameter int          PIPE_SPACING = 160,
  parameter int          GAP_H        = 120,
  parameter int          GAP_MIN      = 60,
  parameter int          SPEED        = 2,
  parameter int          BIRD_X       = 160,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        halt,
  output logic [43:0] pipe_x,
  output logic [35:0] gap_top,
  output logic        running,
  output logic        busy,
  output logic [7:0]  score,
  output logic        score_pulse,
  output logic        tick_overrun
);

  // Parameter sanity: the port widths assume four pipes, the sweep assumes a
  // pipe cannot skip a whole pitch in one frame, and the gap must fit on screen.
  if (NUM_PIPES != 4) begin : g_bad_num_pipes
    $error("pipe_scheduler: NUM_PIPES must be 4");
  end
  if (SPEED < 1 || SPEED >= PIPE_SPACING) begin : g_bad_speed
    $error("pipe_scheduler: SPEED must be in 1..PIPE_SPACING-1");
  end
  if (GAP_MIN + 127 + GAP_H > 511) begin : g_bad_gap
    $error("pipe_scheduler: gap does not fit 9-bit rows");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("pipe_scheduler: LFSR_SEED must be nonzero");
  end

  localparam logic [1:0]  LAST_IDX  = 2'(NUM_PIPES - 1);
  localparam logic [10:0] SPEED_X   = 11'(SPEED);
  localparam logic [10:0] WRAP_X    = 11'(NUM_PIPES * PIPE_SPACING - SPEED);
  localparam logic [11:0] PIPE_W_X  = 12'(PIPE_W);
  localparam logic [11:0] BIRD_X_X  = 12'(BIRD_X);
  localparam logic [8:0]  GAP_MIN_G = 9'(GAP_MIN);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic        halt_seen_q;
  logic [10:0] x_q [NUM_PIPES];
  logic [8:0]  g_q [NUM_PIPES];
  logic [15:0] lfsr_q;
  logic [7:0]  score_q;
  logic        score_pulse_q;
  logic        overrun_q;

  logic        reinit;
  logic        sweep_start;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    reinit      = 1'b0;
    sweep_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_RUN;
          reinit  = 1'b1;
        end
      end
      ST_RUN: begin
        // halt wins over a same-cycle tick; that tick is simply lost.
        if (halt) begin
          state_d = ST_HALTED;
        end else if (frame_tick) begin
          state_d     = ST_UPDATE;
          sweep_start = 1'b1;
        end
      end
      ST_UPDATE: begin
        // The sweep always completes; a halt seen anywhere in it (including
        // the last cycle) is honoured only once all pipes are consistent.
        if (idx_q == LAST_IDX) begin
          state_d = (halt_seen_q || halt) ? ST_HALTED : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------- per-pipe update
  logic [10:0] cur_x;
  logic [10:0] next_x;
  logic        respawn;
  logic        passed;
  logic [15:0] lfsr_next;
  logic [8:0]  new_gap;

  always_comb begin
    cur_x     = x_q[idx_q];
    respawn   = (cur_x < SPEED_X);
    next_x    = respawn ? (cur_x + WRAP_X) : (cur_x - SPEED_X);
    // Right edge was past the bird and is now at or behind it.
    passed    = !respawn &&
                (({1'b0, cur_x} + PIPE_W_X) > BIRD_X_X) &&
                (({1'b0, next_x} + PIPE_W_X) <= BIRD_X_X);
    // Galois LFSR, shift right; gap uses the value before the step.
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    new_gap   = GAP_MIN_G + {2'b00, lfsr_q[6:0]};
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= 11'(SCREEN_W + i * PIPE_SPACING);
        g_q[i] <= GAP_MIN_G;
      end
      lfsr_q        <= LFSR_SEED;
      score_q       <= 8'd0;
      idx_q         <= 2'd0;
      halt_seen_q   <= 1'b0;
      score_pulse_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      score_pulse_q <= 1'b0;
      overrun_q     <= frame_tick && (state_q == ST_UPDATE);
      if (reinit) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          x_q[i] <= 11'(SCREEN_W + i * PIPE_SPACING);
          g_q[i] <= GAP_MIN_G;
        end
        lfsr_q      <= LFSR_SEED;
        score_q     <= 8'd0;
        idx_q       <= 2'd0;
        halt_seen_q <= 1'b0;
      end else if (sweep_start) begin
        idx_q       <= 2'd0;
        halt_seen_q <= 1'b0;
      end else if (state_q == ST_UPDATE) begin
        x_q[idx_q] <= next_x;
        if (respawn) begin
          g_q[idx_q] <= new_gap;
          lfsr_q     <= lfsr_next;
        end
        if (passed) begin
          score_pulse_q <= 1'b1;
          if (score_q != 8'hFF) begin
            score_q <= score_q + 8'd1;
          end
        end
        idx_q       <= idx_q + 2'd1;
        halt_seen_q <= halt_seen_q | halt;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pack
    assign pipe_x[i*11 +: 11] = x_q[i];
    assign gap_top[i*9 +: 9]  = g_q[i];
  end

  assign running      = (state_q == ST_RUN) || (state_q == ST_UPDATE);
  assign busy         = (state_q == ST_UPDATE);
  assign score        = score_q;
  assign score_pulse  = score_pulse_q;
  assign tick_overrun = overrun_q;

endmodule
